// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between MIPS instruction fetch and load/store.
// Data side has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_rdata,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      state_next;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_next;
    logic        rsp_owner_d;
    logic        rsp_is_wr;
    logic        grant_if;
    logic        grant_d;

    // Grant selection: data wins unless fetch has waited through STARVE_MAX data grants.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (rst) begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end else if (if_req_valid && d_req_valid) begin
            if (starve_cnt == STARVE_LIM) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (if_req_valid) begin
            grant_if = 1'b1;
        end else if (d_req_valid) begin
            grant_d = 1'b1;
        end else begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end
    end

    // Memory drive from the winning port in the grant cycle.
    always_comb begin
        if_req_ready = grant_if;
        d_req_ready  = grant_d;
        mem_en       = grant_if | grant_d;
        mem_we       = 1'b0;
        mem_addr     = {ADDR_W{1'b0}};
        mem_wdata    = {DATA_W{1'b0}};
        if (grant_d) begin
            mem_we    = d_req_we;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
        end else if (grant_if) begin
            mem_addr  = if_req_addr;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Starvation count and next-state logic.
    always_comb begin
        starve_next = 4'd0;
        state_next  = IDLE;
        if (grant_d && if_req_valid) begin
            starve_next = (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
        end else begin
            starve_next = 4'd0;
        end
        case (state)
            IDLE:    state_next = (grant_if || grant_d) ? RESP : IDLE;
            RESP:    state_next = (grant_if || grant_d) ? RESP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, starvation counter and response bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            rsp_owner_d <= 1'b0;
            rsp_is_wr   <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            if (grant_if || grant_d) begin
                rsp_owner_d <= grant_d;
                rsp_is_wr   <= grant_d & d_req_we;
            end else begin
                rsp_owner_d <= rsp_owner_d;
                rsp_is_wr   <= rsp_is_wr;
            end
        end
    end

    // Response steering; gated by rst so an in-flight response is dropped on reset.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_rdata = {DATA_W{1'b0}};
        d_rsp_valid  = 1'b0;
        d_rsp_rdata  = {DATA_W{1'b0}};
        if (!rst && state == RESP) begin
            if (rsp_owner_d) begin
                d_rsp_valid = 1'b1;
                d_rsp_rdata = rsp_is_wr ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
                if_rsp_valid = 1'b1;
                if_rsp_rdata = mem_rdata;
            end
        end else begin
            if_rsp_valid = 1'b0;
            d_rsp_valid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomised and directed bench for mips_mem_arbiter: behavioural grant/response model plus a
// bench-side synchronous memory with a shadow copy for expected read data.
module tb_mips_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_rdata;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Preload pattern: word 0 = 0x2008_0005, word 1 = 0x2009_0006, word 2 = 0x200A_0007 ...
    function automatic logic [31:0] init_word(input int idx);
        return 32'h2008_0005 + 32'(idx) * 32'h0001_0001;
    endfunction

    // Bench memory (256 words), synchronous read, one access per cycle.
    logic [31:0] mem_arr [256];
    bit          mem_wr  [256];
    initial mem_rdata = 32'd0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr[9:2]] <= mem_wdata;
                mem_wr[mem_addr[9:2]]  <= 1'b1;
            end else begin
                mem_rdata <= mem_wr[mem_addr[9:2]] ? mem_arr[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    int          starve_m = 0;
    bit          pend_v = 1'b0;
    bit          pend_d = 1'b0;
    logic [31:0] pend_data = 32'd0;

    int n_pass = 0;
    int n_total = 0;

    // observations from the last step
    int          obs_grant;
    logic        obs_if_rv, obs_d_rv;
    logic [31:0] obs_if_rd, obs_d_rd;

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic step(input bit r, input bit iv, input logic [31:0] ia,
                        input bit dv, input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        int g;
        int idx;
        @(negedge clk);
        rst = r; if_req_valid = iv; if_req_addr = ia;
        d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
        #1;
        // grant: 0 none, 1 fetch, 2 data
        if (r) g = 0;
        else if (iv && dv) g = (starve_m == SM) ? 1 : 2;
        else if (iv) g = 1;
        else if (dv) g = 2;
        else g = 0;
        chk("if_req_ready", {31'd0, if_req_ready}, {31'd0, g == 1});
        chk("d_req_ready",  {31'd0, d_req_ready},  {31'd0, g == 2});
        chk("mem_en",       {31'd0, mem_en},       {31'd0, g != 0});
        chk("mem_we",       {31'd0, mem_we},       {31'd0, g == 2 && dwe});
        chk("mem_addr",  mem_addr,  (g == 1) ? ia : (g == 2) ? da : 32'd0);
        chk("mem_wdata", mem_wdata, (g == 2) ? dwd : 32'd0);
        chk("if_rsp_valid", {31'd0, if_rsp_valid}, {31'd0, !r && pend_v && !pend_d});
        chk("if_rsp_rdata", if_rsp_rdata, (!r && pend_v && !pend_d) ? pend_data : 32'd0);
        chk("d_rsp_valid",  {31'd0, d_rsp_valid},  {31'd0, !r && pend_v && pend_d});
        chk("d_rsp_rdata",  d_rsp_rdata, (!r && pend_v && pend_d) ? pend_data : 32'd0);
        obs_grant = if_req_ready ? 1 : (d_req_ready ? 2 : 0);
        obs_if_rv = if_rsp_valid; obs_if_rd = if_rsp_rdata;
        obs_d_rv  = d_rsp_valid;  obs_d_rd  = d_rsp_rdata;
        // advance model
        pend_v = (g != 0);
        pend_d = (g == 2);
        pend_data = 32'd0;
        if (g == 1) begin
            idx = int'(ia[9:2]);
            pend_data = ref_rd(idx);
        end else if (g == 2) begin
            idx = int'(da[9:2]);
            if (dwe) begin
                ref_mem[idx] = dwd;
                ref_wr[idx]  = 1'b1;
            end else begin
                pend_data = ref_rd(idx);
            end
        end
        if (r) starve_m = 0;
        else if (g == 2 && iv) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
        else starve_m = 0;
    endtask

    initial begin
        logic [19:0] pat;
        bit          ip, dp, dw;
        logic [31:0] ia, da, dd;
        for (int i = 0; i < 256; i++) begin
            ref_wr[i] = 1'b0;
            ref_mem[i] = 32'd0;
        end
        rst = 1'b1; if_req_valid = 1'b0; if_req_addr = 32'd0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'd0; d_req_wdata = 32'd0;

        // reset state
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'd0);
        chk("rst_no_grant", obs_grant, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);

        // fetch 0,4,8 back to back, first cycle after reset release
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("if0_grant", obs_grant, 32'd1);
        step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("if0_rsp", obs_if_rd, 32'h2008_0005);
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("if4_rsp", obs_if_rd, 32'h2009_0006);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("if8_rsp", obs_if_rd, 32'h200A_0007);

        // store then load same address
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        chk("st_ack_valid", {31'd0, obs_d_rv}, 32'd1);
        chk("st_ack_rdata", obs_d_rd, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("ld_after_st", obs_d_rd, 32'hDEAD_BEEF);

        // both held valid for 10 cycles
        pat = 20'd0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'd0);
            pat = {pat[17:0], 2'(obs_grant)};
        end
        chk("starve_pattern", {12'd0, pat}, {12'd0, 20'b1010_1010_0110_1010_1001});
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // simultaneous with zero starvation: data first, fetch next
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h24, 32'd0);
        chk("both_d_first", obs_grant, 32'd2);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("if_after_d", obs_grant, 32'd1);

        // reset right after a load grant drops the response
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst_drop_rsp", {31'd0, obs_d_rv}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        chk("rst_resume", obs_grant, 32'd2);
        chk("rst_no_stale", {31'd0, obs_d_rv}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst_resume_data", obs_d_rd, 32'hDEAD_BEEF);

        // idle
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("idle_starve", starve_m, 32'd0);

        // random traffic with requesters holding until accepted
        ip = 1'b0; dp = 1'b0; dw = 1'b0; ia = 32'd0; da = 32'd0; dd = 32'd0;
        for (int c = 0; c < 600; c++) begin
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1'b1;
                ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 15) == 0) ia[1:0] = 2'($urandom_range(1, 3));
            end
            if (!dp && $urandom_range(0, 3) != 0) begin
                dp = 1'b1;
                dw = 1'($urandom_range(0, 1));
                da = {22'd0, 6'($urandom_range(0, 63)), 2'b00, 2'b00};
                dd = $urandom;
            end
            step(($urandom_range(0, 63) == 0), ip, ia, dp, dw, da, dd);
            if (obs_grant == 1) ip = 1'b0;
            if (obs_grant == 2) dp = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
